// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FSM state encoding and IEEE-754 single constants
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_Z
  } fpu_state_e;

  localparam logic [31:0] QNAN  = 32'hFFC00000;
  localparam logic [31:0] PINF  = 32'h7F800000;
  localparam logic [31:0] NINF  = 32'hFF800000;
  localparam logic [31:0] PZERO = 32'h00000000;

endpackage

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - DEPTH x 32 result FIFO with occupancy count
module fpu_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [31:0]              push_data,
  input  logic                     pop,
  output logic [31:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_add_initiator.sv
// rtl/fpu_add_initiator.sv - drives operand/result stb-ack handshake to the FPU adder
module fpu_add_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] input_a,
  output logic [31:0] input_b,
  output logic        input_a_stb,
  output logic        input_b_stb,
  input  logic        input_a_ack,
  input  logic        input_b_ack,
  input  logic [31:0] output_z,
  input  logic        output_z_stb,
  output logic        ack_output,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [15:0] op_count,
  output logic        timeout,
  input  logic        timeout_clr
);

  import fpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  fpu_state_e    state_q;
  fpu_state_e    state_d;
  logic [31:0]   a_d;
  logic [31:0]   b_d;
  logic          a_stb_d;
  logic          b_stb_d;
  logic          ack_d;

  logic          op_fire;
  logic          a_xfer;
  logic          b_xfer;
  logic          z_xfer;
  logic          wd_clear;
  logic [WW-1:0] wd_cnt;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  assign op_ready = (state_q == IDLE) && (fifo_count < DEPTH_CNT);
  assign op_fire  = op_valid && op_ready;
  assign a_xfer   = input_a_stb && input_a_ack;
  assign b_xfer   = input_b_stb && input_b_ack;
  assign z_xfer   = output_z_stb && ack_output;
  assign res_valid = !fifo_empty;

  always_comb begin
    state_d = state_q;
    a_d     = input_a;
    b_d     = input_b;
    a_stb_d = input_a_stb;
    b_stb_d = input_b_stb;
    ack_d   = ack_output;
    case (state_q)
      IDLE: begin
        if (op_fire) begin
          a_d     = op_a;
          b_d     = op_b;
          a_stb_d = 1'b1;
          state_d = SEND_A;
        end
      end
      SEND_A: begin
        if (a_xfer) begin
          a_stb_d = 1'b0;
          b_stb_d = 1'b1;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (b_xfer) begin
          b_stb_d = 1'b0;
          ack_d   = 1'b1;
          state_d = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (z_xfer) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      input_a     <= '0;
      input_b     <= '0;
      input_a_stb <= 1'b0;
      input_b_stb <= 1'b0;
      ack_output  <= 1'b0;
    end else begin
      state_q     <= state_d;
      input_a     <= a_d;
      input_b     <= b_d;
      input_a_stb <= a_stb_d;
      input_b_stb <= b_stb_d;
      ack_output  <= ack_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (z_xfer) begin
      op_count <= op_count + 1'b1;
    end
  end

  // Any handshake counts as progress; the flag stays set until explicitly cleared.
  assign wd_clear = (state_q == IDLE) || a_xfer || b_xfer || z_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (timeout_clr) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else if (wd_clear) begin
      wd_cnt <= '0;
    end else if (wd_cnt == WD_LAST) begin
      timeout <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  fpu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (z_xfer),
    .push_data (output_z),
    .pop       (res_ready),
    .head      (res_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Admission control guarantees a free slot for every result.
  assert property (@(posedge clk) disable iff (!rst_n) !(z_xfer && fifo_full));

endmodule

// File: doc/fpu_add_initiator.md
# fpu_add_initiator

Initiator for the FPU adder's stb/ack operand and result handshake. Accepts operand pairs from a valid/ready upstream port and drives A, then B, to the adder. Collects each result with the adder-side ack and buffers it in a small FIFO for a valid/ready downstream consumer. It sits between the instruction/test sequencer and the adder core, with at most one operation in flight.

## Interface
- `DEPTH`, default 4: result FIFO entries; power of two, ≥2.
- `TIMEOUT`, default 1024: cycles without handshake progress before `timeout` sets; ≥2.
- `clk`  in  1  clock; all logic on its rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `op_valid`  in  1  upstream operand pair valid.
- `op_ready`  out  1  upstream may transfer this cycle.
- `op_a`, `op_b`  in  32  IEEE-754 single operands.
- `input_a`, `input_b`  out  32  operands to adder.
- `input_a_stb`, `input_b_stb`  out  1  operand strobes to adder.
- `input_a_ack`, `input_b_ack`  in  1  adder operand acks.
- `output_z`  in  32  adder result.
- `output_z_stb`  in  1  adder result strobe.
- `ack_output`  out  1  result ack to adder.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  downstream accepts head.
- `res_data`  out  32  FIFO head.
- `op_count`  out  16  completed results written to FIFO; wraps 0xFFFF→0.
- `timeout`  out  1  sticky watchdog flag.
- `timeout_clr`  in  1  clears `timeout`.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z.
- IDLE:
  - `op_ready` = (state==IDLE) && FIFO count < DEPTH; combinational from registered state and count.
  - On edge with `op_valid && op_ready`: latch `op_a`/`op_b` into `input_a`/`input_b`, set `input_a_stb`, go to SEND_A.
- SEND_A: on edge with `input_a_stb && input_a_ack`, clear `input_a_stb`, set `input_b_stb`, go to SEND_B.
- SEND_B: on edge with `input_b_stb && input_b_ack`, clear `input_b_stb`, set `ack_output`, go to WAIT_Z.
- WAIT_Z: on edge with `output_z_stb && ack_output`:
  - push `output_z` into the FIFO;
  - clear `ack_output`;
  - increment `op_count`;
  - go to IDLE.
- Strobes and ack are registered. Once raised, each is held, with `input_a`/`input_b` stable, until its transfer edge. They are never withdrawn early.
- The FIFO never overflows. Admission requires a free slot, and only pops can occur while an operation is in flight.
- FIFO:
  - Pop on edge with `res_valid && res_ready`.
  - Simultaneous push and pop on a full FIFO is impossible. On a non-full FIFO both take effect and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Watchdog:
  - Counter clears in IDLE and on every transfer edge. It increments each cycle otherwise.
  - On reaching TIMEOUT-1, `timeout` sets and the counter saturates.
  - The FSM is not aborted; it keeps waiting.
  - `timeout_clr` clears the flag and the counter. If a set and a clear occur in the same cycle, the clear wins.

## Timing
- Reset values: state IDLE; `input_a_stb`/`input_b_stb`/`ack_output` 0; `input_a`/`input_b` 0; FIFO empty (`res_valid` 0, `res_data` 0); `op_count` 0; `timeout` 0; `op_ready` 1 after reset.
- Reset mid-operation discards the in-flight operation and drops all strobes immediately. The adder must be reset in the same cycle at system level.
- Each strobe/ack rises the cycle after the previous transfer edge. With a zero-wait responder, issue overhead is 3 cycles plus adder compute.
- `res_valid` rises the cycle after the z transfer edge. No FIFO bypass.
- Next `op_ready` is earliest the cycle after return to IDLE, so one idle cycle occurs between operations.

## Structure
- Shared package `fpu_pkg`: state enum, IEEE constants (QNAN 32'hFFC00000, PINF 32'h7F800000, NINF 32'hFF800000, PZERO 32'h0).
- One sub-module, `fpu_result_fifo` (parameter DEPTH; width 32; push/pop/count/full/empty).
- FSM, watchdog and counter stay in the top module.

## Test plan
- 32'h3F800000 + 32'h40000000 (1.0+2.0) via real adder → `res_data` 32'h40400000, `op_count` 1.
- 32'h3F800000 + 32'hBF800000 → 32'h00000000 (positive zero).
- 32'h7F800000 + 32'hFF800000 → 32'hFFC00000.
- `res_ready`=0, DEPTH ops offered back-to-back:
  - DEPTH results buffered;
  - `op_ready` low with FIFO full;
  - release drains them in order.
- Model responder holds `input_b_ack`=0:
  - `timeout` sets exactly TIMEOUT cycles after entering SEND_B;
  - `timeout_clr` clears it;
  - a later ack completes normally.
- Assert `rst_n` low in WAIT_Z → all outputs at reset values the same cycle; next op completes correctly.
